// File: rtl/vga_sync_monitor.sv
// VGA sync monitor: recovers h/v counters from sampled syncs, locks after
// clean frames, then emits active pixels and a per-frame rgb checksum.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 526,
  parameter int V_SYNC      = 2,
  parameter int H_ACT_START = 145,
  parameter int H_ACT_END   = 783,
  parameter int V_ACT_START = 36,
  parameter int V_ACT_END   = 514,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk25MHz,
  input  logic        rst,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [3:0]  i_red,
  input  logic [3:0]  i_green,
  input  logic [3:0]  i_blue,
  output logic        o_locked,
  output logic        o_px_valid,
  output logic [9:0]  o_px_x,
  output logic [9:0]  o_px_y,
  output logic [11:0] o_px_rgb,
  output logic        o_frame_done,
  output logic [23:0] o_frame_sum,
  output logic [7:0]  o_err_cnt
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_N    = 10'(V_SYNC);
  localparam logic [9:0] HA_S    = 10'(H_ACT_START);
  localparam logic [9:0] HA_E    = 10'(H_ACT_END);
  localparam logic [9:0] VA_S    = 10'(V_ACT_START);
  localparam logic [9:0] VA_E    = 10'(V_ACT_END);
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic        hs_p_q, hs_p_d, vs_p_q, vs_p_d;
  logic [11:0] rgb_q, rgb_d;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [7:0]  good_q, good_d;
  logic [23:0] acc_q, acc_d;
  logic        locked_q, locked_d;
  logic        valid_q, valid_d;
  logic [9:0]  px_x_q, px_x_d, px_y_q, px_y_d;
  logic [11:0] px_rgb_q, px_rgb_d;
  logic        done_q, done_d;
  logic [23:0] sum_q, sum_d;
  logic [7:0]  err_q, err_d;

  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic in_win, active, err_any;

  always_comb begin
    hs_d   = i_hsync;
    vs_d   = i_vsync;
    rgb_d  = {i_red, i_green, i_blue};
    hs_p_d = hs_q;
    vs_p_d = vs_q;

    hs_rise = hs_q & ~hs_p_q;
    hs_fall = ~hs_q & hs_p_q;
    vs_rise = vs_q & ~vs_p_q;
    vs_fall = ~vs_q & vs_p_q;

    hcnt_d = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1;
    if (hs_rise) hcnt_d = '0;
    vcnt_d = vcnt_q;
    if (hs_rise) begin
      if (vs_rise)                vcnt_d = '0;
      else if (vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
    end

    in_win = (hcnt_q >= HA_S) && (hcnt_q <= HA_E) &&
             (vcnt_q >= VA_S) && (vcnt_q <= VA_E);
    active = in_win && (state_q == LOCKED);

    // Several faults in one cycle still count as a single error.
    err_any = (state_q != SEARCH) && (
      (hs_rise && hcnt_q != H_LAST) ||
      (hs_fall && hcnt_q != HS_LAST) ||
      (vs_rise && !hs_rise) ||
      (vs_rise && vcnt_q != V_LAST) ||
      (vs_fall && vcnt_q != VS_N) ||
      (hcnt_q == CNT_MAX) || (vcnt_q == CNT_MAX) ||
      (state_q == LOCKED && !in_win && rgb_q != '0));

    state_d  = state_q;
    good_d   = good_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    done_d   = 1'b0;
    err_d    = err_q;
    valid_d  = active;
    px_x_d   = px_x_q;
    px_y_d   = px_y_q;
    px_rgb_d = px_rgb_q;

    if (active) begin
      px_x_d   = hcnt_q - HA_S;
      px_y_d   = vcnt_q - VA_S;
      px_rgb_d = rgb_q;
    end

    if (err_any) begin
      state_d = SEARCH;
      acc_d   = '0;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (hs_rise && vs_rise) begin
            state_d = MEASURE;
            good_d  = '0;
          end
        end
        MEASURE: begin
          if (vs_rise) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 == LOCK_N) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (active) acc_d = acc_q + {12'd0, rgb_q};
          if (vs_rise) begin
            sum_d  = acc_q;
            done_d = 1'b1;
            acc_d  = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk25MHz or negedge rst) begin
    if (!rst) begin
      state_q  <= SEARCH;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      hs_p_q   <= 1'b0;
      vs_p_q   <= 1'b0;
      rgb_q    <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      good_q   <= '0;
      acc_q    <= '0;
      locked_q <= 1'b0;
      valid_q  <= 1'b0;
      px_x_q   <= '0;
      px_y_q   <= '0;
      px_rgb_q <= '0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      hs_p_q   <= hs_p_d;
      vs_p_q   <= vs_p_d;
      rgb_q    <= rgb_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      good_q   <= good_d;
      acc_q    <= acc_d;
      locked_q <= locked_d;
      valid_q  <= valid_d;
      px_x_q   <= px_x_d;
      px_y_q   <= px_y_d;
      px_rgb_q <= px_rgb_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      err_q    <= err_d;
    end
  end

  assign o_locked     = locked_q;
  assign o_px_valid   = valid_q;
  assign o_px_x       = px_x_q;
  assign o_px_y       = px_y_q;
  assign o_px_rgb     = px_rgb_q;
  assign o_frame_done = done_q;
  assign o_frame_sum  = sum_q;
  assign o_err_cnt    = err_q;

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 The block SHALL have parameter H_TOTAL, default 800, clocks per line.
REQ-002 The block SHALL have parameter H_SYNC, default 96, hsync-high clocks per line.
REQ-003 The block SHALL have parameter V_TOTAL, default 526, lines per frame.
REQ-004 The block SHALL have parameter V_SYNC, default 2, vsync-high lines per frame.
REQ-005 The block SHALL have parameters H_ACT_START/H_ACT_END, defaults 145/783, inclusive active x-window in recovered counts.
REQ-006 The block SHALL have parameters V_ACT_START/V_ACT_END, defaults 36/514, inclusive active y-window.
REQ-007 The block SHALL have parameter LOCK_FRAMES, default 2, consecutive error-free frames required to lock.
REQ-008 Ports SHALL be: clk25MHz input 1 pixel clock; rst input 1 asynchronous active-low reset; i_hsync input 1 active-high; i_vsync input 1 active-high; i_red/i_green/i_blue input 4 each; o_locked output 1; o_px_valid output 1; o_px_x output 10; o_px_y output 10; o_px_rgb output 12 {r,g,b}; o_frame_done output 1 pulse; o_frame_sum output 24; o_err_cnt output 8.
REQ-009 Reset: rst asynchronous, active-low; clock: clk25MHz.

Function
REQ-010 All inputs SHALL be registered once (sample stage); edges are detected by comparing sample against its previous value.
REQ-011 hcnt (10 bit) SHALL load 0 on a sampled hsync rising edge, else increment, saturating at 1023.
REQ-012 vcnt (10 bit) SHALL increment on each hsync rising edge, load 0 when vsync and hsync rising edges occur in the same cycle, saturate at 1023.
REQ-013 FSM states SHALL be SEARCH, MEASURE, LOCKED; reset state SEARCH.
REQ-014 SEARCH -> MEASURE on coincident hsync+vsync rising edge; good-frame counter cleared.
REQ-015 In MEASURE, each vsync rising edge with no error since the previous one SHALL increment the good-frame counter; on reaching LOCK_FRAMES -> LOCKED the next cycle.
REQ-016 Errors (checked in MEASURE and LOCKED only): hsync rising edge with hcnt != H_TOTAL-1; hsync falling edge with hcnt != H_SYNC-1; vsync rising edge not coincident with hsync rising edge; vsync rising edge with vcnt != V_TOTAL-1; vsync falling edge with vcnt != V_SYNC; hcnt or vcnt saturated; in LOCKED only, nonzero rgb sample outside active window.
REQ-017 Any error SHALL force state to SEARCH next cycle and increment o_err_cnt by exactly 1 per erroring cycle regardless of how many conditions fire; o_err_cnt saturates at 255 and clears only on reset.
REQ-018 o_locked SHALL be 1 exactly while state is LOCKED.
REQ-019 In LOCKED, a sample is active when hcnt in [H_ACT_START,H_ACT_END] and vcnt in [V_ACT_START,V_ACT_END]; one cycle later o_px_valid=1, o_px_x=hcnt-H_ACT_START, o_px_y=vcnt-V_ACT_START, o_px_rgb=sample; pin-to-output latency 2 clocks.
REQ-020 When not active, o_px_valid=0 and o_px_x/o_px_y/o_px_rgb SHALL hold their last values.
REQ-021 A 24-bit accumulator SHALL add each active 12-bit rgb modulo 2^24.
REQ-022 On a vsync rising edge in LOCKED, o_frame_sum SHALL load the accumulator, o_frame_done pulses 1 cycle, accumulator clears; on leaving LOCKED the accumulator clears and no o_frame_done is issued.
REQ-023 The edge that causes MEASURE -> LOCKED SHALL NOT produce o_frame_done; the first pulse follows the first full locked frame.

Reset
REQ-024 While rst=0: state SEARCH, hcnt=vcnt=0, sample registers 0, o_locked=0, o_px_valid=0, o_px_x=o_px_y=0, o_px_rgb=0, o_frame_done=0, o_frame_sum=0, o_err_cnt=0, accumulator 0, good-frame counter 0.
REQ-025 Reset asserted mid-frame SHALL take effect immediately; after release the block re-locks only through SEARCH/MEASURE.

Verification
REQ-026 Nominal 800x526 timing, constant rgb 0xFFF active, 0 blanking -> o_locked rises after 3rd coincident vsync edge; after 1 further frame o_frame_done with o_frame_sum=0xB5645F; o_err_cnt=0.
REQ-027 Locked, one line shortened to 799 clocks -> o_err_cnt=1, o_locked=0 next cycle, re-lock after 3 further good vsync edges.
REQ-028 Locked, first active pixel rgb=0x123 -> o_px_valid=1, o_px_x=0, o_px_y=0, o_px_rgb=0x123 two clocks after pin change.
REQ-029 Locked, rgb=0x001 at hcnt=100 -> blanking error, o_err_cnt increments, o_locked falls; 300 forced errors -> o_err_cnt stays 255.
REQ-030 Reset pulsed mid-active-line -> all outputs return to REQ-024 values within the reset cycle; no o_frame_done until re-lock plus one frame.
